ram_line_responder: RTL and testbench

- Memory-side end of the cache-to-RAM interface: responds to the cache controller's RAMreadEnable / RAMwriteEnable requests.
- Owns the backing line-organised RAM array.
- Read request: streams one full cache line out word-serially to the cache.
- Write request (write-back): pulls one full line in word-serially from the cache. Each request ends with a one-cycle done pulse.

---
 rtl/ram_line_if.sv | 30 +++
 rtl/ram_line_responder.sv | 131 +++++++++++++
 tb/tb_ram_line_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ram_line_if.sv
// Cache-to-RAM line transfer bus. The cache controller is the master and the
// line responder is the slave.
interface ram_line_if #(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LINE_WORDS = 4
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic                  RAMreadEnable;
    logic                  RAMwriteEnable;
    logic [ADDR_WIDTH-1:0] lineAddr;
    logic [WORD_WIDTH-1:0] wrData;
    logic [WORD_WIDTH-1:0] rdData;
    logic                  rdValid;
    logic                  wrStrobe;
    logic [IDX_W-1:0]      wordIdx;
    logic                  busy;
    logic                  done;

    modport master (
        output RAMreadEnable, RAMwriteEnable, lineAddr, wrData,
        input  rdData, rdValid, wrStrobe, wordIdx, busy, done
    );

    modport slave (
        input  RAMreadEnable, RAMwriteEnable, lineAddr, wrData,
        output rdData, rdValid, wrStrobe, wordIdx, busy, done
    );
endinterface

// File: rtl/ram_line_responder.sv
// Memory-side line responder: owns a line-organised RAM and serves whole-line
// fetches and write-backs word-serially, ending each request with a done pulse.
module ram_line_responder #(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LINE_WORDS = 4,
    parameter int ACCESS_LAT = 2
) (
    input  logic         clk,
    input  logic         clr,
    ram_line_if.slave    bus
);
    localparam int IDX_W  = $clog2(LINE_WORDS);
    localparam int MEM_AW = ADDR_WIDTH + IDX_W;
    localparam int DEPTH  = 1 << MEM_AW;
    localparam int LAT_W  = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((ACCESS_LAT > 0) ? ACCESS_LAT - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_WORDS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_RBURST = 3'd2;
    localparam logic [2:0] S_WBURST = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  is_wr_q, is_wr_d;
    logic                  mem_we_d;
    logic [MEM_AW-1:0]     mem_idx_s;
    logic [WORD_WIDTH-1:0] mem_q [DEPTH];

    // Line address concatenated with word index never overflows the array.
    assign mem_idx_s = {addr_q, idx_q};

    // Next-state logic: request acceptance, access wait, burst sequencing.
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        is_wr_d  = is_wr_q;
        mem_we_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.RAMwriteEnable || bus.RAMreadEnable) begin
                    // Write wins on a tie: the cache must write back before it fetches.
                    addr_d  = bus.lineAddr;
                    is_wr_d = bus.RAMwriteEnable;
                    lat_d   = {LAT_W{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    if (ACCESS_LAT == 0) begin
                        state_d = bus.RAMwriteEnable ? S_WBURST : S_RBURST;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    lat_d   = {LAT_W{1'b0}};
                    state_d = is_wr_q ? S_WBURST : S_RBURST;
                end else begin
                    lat_d   = lat_q + LAT_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_RBURST, S_WBURST: begin
                mem_we_d = (state_q == S_WBURST);
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = state_q;
                end
            end
            S_DONE: begin
                idx_d   = {IDX_W{1'b0}};
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                lat_d   = {LAT_W{1'b0}};
                idx_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            lat_q   <= {LAT_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            addr_q  <= {ADDR_WIDTH{1'b0}};
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            is_wr_q <= is_wr_d;
        end
    end

    // Backing array write port; contents deliberately survive a clear.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_idx_s] <= bus.wrData;
        end
    end

    // Outputs decode straight from the state registers so a clear zeroes them at once.
    always_comb begin
        bus.rdValid  = (state_q == S_RBURST);
        bus.wrStrobe = (state_q == S_WBURST);
        bus.busy     = (state_q == S_WAIT) || (state_q == S_RBURST) || (state_q == S_WBURST);
        bus.done     = (state_q == S_DONE);
        bus.wordIdx  = idx_q;
        if (state_q == S_RBURST) begin
            bus.rdData = mem_q[mem_idx_s];
        end else begin
            bus.rdData = {WORD_WIDTH{1'b0}};
        end
    end
endmodule

// File: tb/tb_ram_line_responder.sv
// Self-checking bench for ram_line_responder: directed table, hand-written
// corner sequences, and randomized requests against a line-array model.
module tb_ram_line_responder;
    localparam int WW  = 8;
    localparam int AW  = 4;
    localparam int LW  = 4;
    localparam int LAT = 2;
    localparam int IW  = 2;
    localparam int LB  = LW * WW;
    localparam int OW  = 4 + IW + WW;

    logic clk = 1'b0;
    logic clr;
    int   errors = 0;
    int   checks = 0;

    logic [WW-1:0] ref_mem [1 << (AW + IW)];

    ram_line_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LINE_WORDS(LW)) bus ();

    ram_line_responder #(
        .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LINE_WORDS(LW), .ACCESS_LAT(LAT)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [LB-1:0] wline;
        logic [LB-1:0] rexp;
        logic          poke;
    } vec_t;

    function automatic logic [OW-1:0] obs();
        return {bus.busy, bus.done, bus.rdValid, bus.wrStrobe, bus.wordIdx, bus.rdData};
    endfunction

    task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {busy,done,rdV,wrS,idx,data}=%h expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // One request from acceptance through done plus two idle cycles, checked per cycle.
    task automatic run_req(input logic wr, input logic rd, input logic [AW-1:0] addr,
                           input logic [LB-1:0] wline, input logic [LB-1:0] rexp,
                           input logic poke, input string name);
        logic          busy_e, done_e, rd_e, wr_e, burst;
        logic [WW-1:0] data_e;
        int            i;
        @(negedge clk);
        bus.RAMwriteEnable = wr;
        bus.RAMreadEnable  = rd;
        bus.lineAddr       = addr;
        for (int k = 1; k <= LAT + LW + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.RAMwriteEnable = 1'b0;
                bus.RAMreadEnable  = poke;
                bus.lineAddr       = poke ? AW'(7) : AW'($urandom);
            end
            if (k == LAT + LW + 1) bus.RAMreadEnable = 1'b0;
            burst  = (k >= LAT + 1) && (k <= LAT + LW);
            i      = burst ? (k - LAT - 1) : 0;
            busy_e = (k <= LAT + LW);
            done_e = (k == LAT + LW + 1);
            rd_e   = burst && !wr;
            wr_e   = burst && wr;
            data_e = rd_e ? rexp[i*WW +: WW] : {WW{1'b0}};
            if (wr_e) begin
                bus.wrData = wline[i*WW +: WW];
                ref_mem[{addr, IW'(i)}] = wline[i*WW +: WW];
            end else begin
                bus.wrData = WW'($urandom);
            end
            check(name, obs(), {busy_e, done_e, rd_e, wr_e, IW'(i), data_e});
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check({name, "_idle"}, obs(), {OW{1'b0}});
        end
    endtask

    vec_t          tbl [10];
    logic [LB-1:0] line_v;
    logic [LB-1:0] rexp_v;
    logic [AW-1:0] a_v;
    int            op;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Line words pack low-first: 32'hDDCCBBAA is words AA,BB,CC,DD.
        tbl[0] = '{wr:1'b1, rd:1'b0, addr:4'd3,  wline:32'hDDCCBBAA, rexp:32'h0,        poke:1'b0};
        tbl[1] = '{wr:1'b0, rd:1'b1, addr:4'd3,  wline:32'h0,        rexp:32'hDDCCBBAA, poke:1'b0};
        tbl[2] = '{wr:1'b1, rd:1'b1, addr:4'd5,  wline:32'h0F1E2D3C, rexp:32'h0,        poke:1'b0};
        tbl[3] = '{wr:1'b0, rd:1'b1, addr:4'd5,  wline:32'h0,        rexp:32'h0F1E2D3C, poke:1'b0};
        tbl[4] = '{wr:1'b1, rd:1'b0, addr:4'd2,  wline:32'h89ABCDEF, rexp:32'h0,        poke:1'b0};
        tbl[5] = '{wr:1'b0, rd:1'b1, addr:4'd2,  wline:32'h0,        rexp:32'h89ABCDEF, poke:1'b1};
        tbl[6] = '{wr:1'b1, rd:1'b0, addr:4'd15, wline:32'h01020304, rexp:32'h0,        poke:1'b0};
        tbl[7] = '{wr:1'b1, rd:1'b0, addr:4'd0,  wline:32'hF0E1D2C3, rexp:32'h0,        poke:1'b0};
        tbl[8] = '{wr:1'b0, rd:1'b1, addr:4'd15, wline:32'h0,        rexp:32'h01020304, poke:1'b0};
        tbl[9] = '{wr:1'b0, rd:1'b1, addr:4'd0,  wline:32'h0,        rexp:32'hF0E1D2C3, poke:1'b0};

        clr = 1'b1;
        bus.RAMreadEnable  = 1'b0;
        bus.RAMwriteEnable = 1'b0;
        bus.lineAddr       = {AW{1'b0}};
        bus.wrData         = {WW{1'b0}};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("reset", obs(), {OW{1'b0}});
        end
        clr = 1'b0;

        for (int v = 0; v < 10; v++) begin
            run_req(tbl[v].wr, tbl[v].rd, tbl[v].addr, tbl[v].wline, tbl[v].rexp,
                    tbl[v].poke, $sformatf("vec%0d", v));
        end

        // Abort mid write-back: preload, overwrite two words, then clear.
        run_req(1'b1, 1'b0, 4'd1, 32'h44332211, 32'h0, 1'b0, "preload1");
        line_v = 32'h88776655;
        @(negedge clk);
        bus.RAMwriteEnable = 1'b1;
        bus.lineAddr       = 4'd1;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            bus.RAMwriteEnable = 1'b0;
            if (k > LAT) bus.wrData = line_v[(k-LAT-1)*WW +: WW];
            if (k > LAT && k < LAT + 3) ref_mem[{4'd1, IW'(k-LAT-1)}] = line_v[(k-LAT-1)*WW +: WW];
            if (k == LAT + 3) begin
                check("abort_pre", obs(), {1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'h00});
                clr = 1'b1;
                #1;
                check("abort_async", obs(), {OW{1'b0}});
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_hold", obs(), {OW{1'b0}});
        end
        clr = 1'b0;
        @(negedge clk);
        check("abort_nodone", obs(), {OW{1'b0}});
        run_req(1'b0, 1'b1, 4'd1, 32'h0, 32'h44336655, 1'b0, "abort_read");

        // Randomized: fill every line, then mix reads/writes checked against the model.
        for (int l = 0; l < (1 << AW); l++) begin
            run_req(1'b1, 1'($urandom_range(0, 1)), AW'(l), LB'($urandom), 32'h0, 1'b0, "fill");
        end
        for (int n = 0; n < 30; n++) begin
            op  = $urandom_range(0, 2);
            a_v = AW'($urandom);
            for (int i = 0; i < LW; i++) rexp_v[i*WW +: WW] = ref_mem[{a_v, IW'(i)}];
            run_req(op != 0, op != 1, a_v, LB'($urandom), rexp_v,
                    1'($urandom_range(0, 1)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
